// File: rtl/sme_trng_health.sv
// Online health tests (repetition count + adaptive proportion) and output
// gating for the raw TRNG lanes feeding the SME Keccak random source.
//
// Ports:
//   g_clk, g_resetn     clock, synchronous active-low reset
//   g_clk_req           clock request (in_valid | out_valid)
//   in_valid, in_bits   raw sample, one bit per lane
//   clr_alarm           clears alarms and restarts all statistics/start-up
//   out_valid, out_bits healthy forwarded sample (single-cycle pulse)
//   alarm               sticky per-lane failure flags
//   ready               start-up complete and no alarm

module sme_trng_health #(
    parameter int NB      = 6,
    parameter int RCT_C   = 8,
    parameter int APT_W   = 64,
    parameter int APT_C   = 48,
    parameter int STARTUP = 1
) (
    input  logic          g_clk,
    input  logic          g_resetn,
    output logic          g_clk_req,
    input  logic          in_valid,
    input  logic [NB-1:0] in_bits,
    input  logic          clr_alarm,
    output logic          out_valid,
    output logic [NB-1:0] out_bits,
    output logic [NB-1:0] alarm,
    output logic          ready
);

    localparam int RW = $clog2(RCT_C + 1);
    localparam int MW = $clog2(APT_C + 1);
    localparam int WW = $clog2(APT_W);
    localparam int SW = (STARTUP > 0) ? $clog2(STARTUP + 1) : 1;

    localparam logic [RW-1:0] RUN_MAX = RW'(RCT_C);
    localparam logic [RW-1:0] RUN_ONE = RW'(1);
    localparam logic [MW-1:0] MAT_MAX = MW'(APT_C);
    localparam logic [MW-1:0] MAT_ONE = MW'(1);
    localparam logic [WW-1:0] W_LAST  = WW'(APT_W - 1);
    localparam logic [SW-1:0] S_DONE  = SW'(STARTUP);

    logic [NB-1:0][RW-1:0] run_q, run_d;
    logic [NB-1:0]         prev_q, prev_d;
    logic [NB-1:0]         ref_q, ref_d;
    logic [NB-1:0][MW-1:0] match_q, match_d;
    logic [WW-1:0]         wcnt_q, wcnt_d;
    logic [SW-1:0]         wins_q, wins_d;
    logic [NB-1:0]         alarm_q, alarm_d;
    logic                  ready_q, ready_d;
    logic                  ovld_q, ovld_d;
    logic [NB-1:0]         obits_q, obits_d;
    logic [NB-1:0]         fail;
    logic                  accept;
    logic                  wrap;

    // A clear in the same cycle as a sample discards the sample.
    assign accept = in_valid & ~clr_alarm;
    assign wrap   = (wcnt_q == W_LAST);

    always_comb begin
        run_d   = run_q;
        prev_d  = prev_q;
        ref_d   = ref_q;
        match_d = match_q;
        wcnt_d  = wcnt_q;
        wins_d  = wins_q;
        alarm_d = alarm_q;
        ready_d = ready_q;
        ovld_d  = 1'b0;
        obits_d = obits_q;
        fail    = '0;

        if (accept) begin
            wcnt_d = wrap ? '0 : wcnt_q + WW'(1);
            if (wrap && (wins_q != S_DONE)) begin
                wins_d = wins_q + SW'(1);
            end

            for (int i = 0; i < NB; i++) begin
                // run==0 only before the first sample since reset/clear.
                if (run_q[i] == '0) begin
                    run_d[i] = RUN_ONE;
                end else if (in_bits[i] == prev_q[i]) begin
                    run_d[i] = (run_q[i] == RUN_MAX) ? RUN_MAX
                                                     : run_q[i] + RUN_ONE;
                end else begin
                    run_d[i] = RUN_ONE;
                end
                prev_d[i] = in_bits[i];

                if (wcnt_q == '0) begin
                    ref_d[i]   = in_bits[i];
                    match_d[i] = MAT_ONE;
                end else if (in_bits[i] == ref_q[i]) begin
                    match_d[i] = (match_q[i] == MAT_MAX) ? MAT_MAX
                                                         : match_q[i] + MAT_ONE;
                end

                fail[i] = (run_d[i] == RUN_MAX) | (match_d[i] == MAT_MAX);
            end

            alarm_d = alarm_q | fail;
            // Gate on post-update state so the failing sample is itself
            // blocked and the window-completing sample is forwarded.
            ready_d = (wins_d == S_DONE) & ~|alarm_d;
            ovld_d  = ready_d;
            if (ready_d) begin
                obits_d = in_bits;
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn || clr_alarm) begin
            run_q   <= '0;
            prev_q  <= '0;
            ref_q   <= '0;
            match_q <= '0;
            wcnt_q  <= '0;
            wins_q  <= '0;
            alarm_q <= '0;
            ready_q <= 1'b0;
            ovld_q  <= 1'b0;
            obits_q <= '0;
        end else begin
            run_q   <= run_d;
            prev_q  <= prev_d;
            ref_q   <= ref_d;
            match_q <= match_d;
            wcnt_q  <= wcnt_d;
            wins_q  <= wins_d;
            alarm_q <= alarm_d;
            ready_q <= ready_d;
            ovld_q  <= ovld_d;
            obits_q <= obits_d;
        end
    end

    assign out_valid = ovld_q;
    assign out_bits  = obits_q;
    assign alarm     = alarm_q;
    assign ready     = ready_q;
    assign g_clk_req = in_valid | ovld_q;

endmodule

// File: tb/tb_sme_trng_health.sv
// Scoreboard bench for sme_trng_health: directed test-plan phases followed
// by randomized traffic, checked against a sample-history reference model.

module tb_sme_trng_health;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       clk_req;
    logic       in_valid = 1'b0;
    logic [5:0] in_bits = '0;
    logic       clr = 1'b0;
    logic       out_valid;
    logic [5:0] out_bits;
    logic [5:0] alarm;
    logic       ready;

    always #5 clk = ~clk;

    sme_trng_health dut (
        .g_clk     (clk),
        .g_resetn  (rstn),
        .g_clk_req (clk_req),
        .in_valid  (in_valid),
        .in_bits   (in_bits),
        .clr_alarm (clr),
        .out_valid (out_valid),
        .out_bits  (out_bits),
        .alarm     (alarm),
        .ready     (ready)
    );

    typedef struct {
        logic       v;
        logic       ov;
        logic [5:0] ob;
        logic [5:0] al;
        logic       rd;
    } exp_t;

    exp_t       stq[$];
    logic [5:0] dq[$];
    logic [5:0] hist[$];
    logic [5:0] m_alarm = '0;
    logic       m_ready = 1'b0;
    logic [5:0] m_bits = '0;
    int         total = 0;
    int         bad = 0;
    int         pulses = 0;
    int         ph = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: statistics recomputed from the full history since clear.
    function automatic logic [5:0] lane_fail();
        logic [5:0] f;
        int n;
        int ws;
        f  = '0;
        n  = hist.size();
        ws = ((n - 1) / 64) * 64;
        for (int i = 0; i < 6; i++) begin
            int run;
            int mt;
            run = 0;
            for (int k = n - 1; k >= 0; k--) begin
                if (hist[k][i] != hist[n-1][i] || run >= 8) break;
                run++;
            end
            if (run >= 8) f[i] = 1'b1;
            mt = 0;
            for (int k = ws; k < n; k++) begin
                if (hist[k][i] == hist[ws][i]) mt++;
            end
            if (mt >= 48) f[i] = 1'b1;
        end
        return f;
    endfunction

    task automatic drive(input logic v, input logic [5:0] b,
                         input logic c, input logic rn);
        exp_t e;
        logic ev;
        @(negedge clk);
        in_valid = v;
        in_bits  = b;
        clr      = c;
        rstn     = rn;
        ev       = 1'b0;
        if (!rn || c) begin
            hist.delete();
            m_alarm = '0;
            m_ready = 1'b0;
            m_bits  = '0;
        end else if (v) begin
            hist.push_back(b);
            m_alarm = m_alarm | lane_fail();
            m_ready = (hist.size() >= 64) && (m_alarm == '0);
            ev      = m_ready;
            if (ev) begin
                m_bits = b;
                dq.push_back(b);
            end
        end
        e.v  = v;
        e.ov = ev;
        e.ob = m_bits;
        e.al = m_alarm;
        e.rd = m_ready;
        stq.push_back(e);
    endtask

    function automatic logic [5:0] alt();
        ph++;
        return ph[0] ? 6'h3f : 6'h00;
    endfunction

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: per-cycle status plus data scoreboard on out_valid.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (stq.size() > 0) begin
            e = stq.pop_front();
            chk("out_valid", 32'(out_valid), 32'(e.ov));
            chk("out_bits", 32'(out_bits), 32'(e.ob));
            chk("alarm", 32'(alarm), 32'(e.al));
            chk("ready", 32'(ready), 32'(e.rd));
            chk("clk_req", 32'(clk_req), 32'(e.v | e.ov));
            if (out_valid === 1'b1) begin
                pulses++;
                if (dq.size() == 0) begin
                    chk("spurious_out", 32'(out_bits), 32'hffff_ffff);
                end else begin
                    chk("sample_data", 32'(out_bits), 32'(dq.pop_front()));
                end
            end
        end
    end

    initial begin
        int p0;
        int nv;
        logic [5:0] b;
        logic [31:0] fl;

        drive(0, '0, 0, 0);
        drive(0, '0, 0, 0);

        // Start-up with alternating lanes.
        p0 = pulses;
        for (int k = 0; k < 130; k++) drive(1, alt(), 0, 1);
        settle();
        chk("startup_pulses", 32'(pulses - p0), 32'd67);
        chk("startup_ready", 32'(ready), 32'd1);

        // Lane 2 stuck at 1.
        for (int k = 0; k < 12; k++) begin
            b = alt();
            b[2] = 1'b1;
            drive(1, b, 0, 1);
        end
        settle();
        chk("rct_lane2", 32'(alarm), 32'h04);
        chk("rct_ready", 32'(ready), 32'd0);

        // Clear, then lane 0 pattern 1111111 0 from a window start.
        drive(0, '0, 1, 1);
        for (int j = 0; j < 53; j++) begin
            b = alt();
            b[0] = (j % 8 != 7);
            drive(1, b, 0, 1);
        end
        settle();
        chk("apt_before", 32'(alarm), 32'h00);
        b = alt();
        b[0] = 1'b1;
        drive(1, b, 0, 1);
        settle();
        chk("apt_at54", 32'(alarm), 32'h01);

        // Clear pulsed together with a valid sample.
        drive(1, 6'h2a, 1, 1);
        settle();
        chk("clr_alarm", 32'(alarm), 32'h00);
        chk("clr_ready", 32'(ready), 32'd0);
        p0 = pulses;
        for (int k = 0; k < 63; k++) drive(1, alt(), 0, 1);
        settle();
        chk("clr_63", 32'(pulses - p0), 32'd0);
        for (int k = 0; k < 7; k++) drive(1, alt(), 0, 1);
        settle();
        chk("clr_70", 32'(pulses - p0), 32'd7);

        // All lanes fail in the same cycle.
        drive(0, '0, 1, 1);
        for (int k = 0; k < 8; k++) drive(1, 6'h00, 0, 1);
        settle();
        chk("multi_lane", 32'(alarm), 32'h3f);

        // Stalls do not advance the run counter.
        drive(0, '0, 1, 1);
        nv = 0;
        for (int j = 0; nv < 8; j++) begin
            if (j % 4 == 0 || j % 4 == 3) begin
                b = alt();
                b[0] = 1'b1;
                drive(1, b, 0, 1);
                nv++;
                if (nv == 7) begin
                    settle();
                    chk("stall_7th", 32'(alarm), 32'h00);
                end
            end else begin
                drive(0, 6'($urandom), 0, 1);
            end
        end
        settle();
        chk("stall_8th", 32'(alarm), 32'h01);

        // Reset mid-window.
        drive(0, '0, 1, 1);
        for (int k = 0; k < 29; k++) drive(1, alt(), 0, 1);
        drive(1, alt(), 0, 0);
        settle();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        p0 = pulses;
        for (int k = 0; k < 64; k++) drive(1, alt(), 0, 1);
        settle();
        chk("rst_window", 32'(pulses - p0), 32'd1);

        // Randomized traffic: near-alternating lanes with sparse flips.
        for (int k = 0; k < 1500; k++) begin
            fl = $urandom & $urandom & $urandom;
            drive($urandom_range(0, 3) != 0, alt() ^ fl[5:0],
                  $urandom_range(0, 255) == 0, $urandom_range(0, 511) != 0);
        end

        drive(0, '0, 0, 1);
        drive(0, '0, 0, 1);
        settle();
        chk("scoreboard_empty", 32'(dq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
